// File: rtl/muldiv_if.sv
// Request/response bundle between the execute-stage controller and the
// iterative multiply-divide unit.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            flush;
  logic            IsMulDiv;
  logic            Busy;
  logic            out_valid;
  logic [XLEN-1:0] Result;

  modport master (
    output in_valid, funct3, funct7, SrcA, SrcB, flush,
    input  in_ready, IsMulDiv, Busy, out_valid, Result
  );

  modport slave (
    input  in_valid, funct3, funct7, SrcA, SrcB, flush,
    output in_ready, IsMulDiv, Busy, out_valid, Result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply-divide unit: shift-add multiplier and
// restoring divider sharing one 2*XLEN accumulator, one bit per cycle.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned DW = 2 * XLEN;
  localparam logic [6:0]  MEXT = 7'b0000001;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic            neg_res;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] result_q;
  logic [DW-1:0]   acc;

  // Request decode: signedness, magnitudes and one-cycle special cases
  logic            is_md, accept, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [2:0]      f3;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  assign f3       = bus.funct3;
  assign is_md    = (bus.funct7 == MEXT);
  assign accept   = bus.in_valid & (state == IDLE) & is_md;
  assign a_sgn    = (f3 == 3'b001) | (f3 == 3'b010) | (f3 == 3'b100) | (f3 == 3'b110);
  assign b_sgn    = (f3 == 3'b001) | (f3 == 3'b100) | (f3 == 3'b110);
  assign a_neg    = a_sgn & bus.SrcA[XLEN-1];
  assign b_neg    = b_sgn & bus.SrcB[XLEN-1];
  assign a_mag    = a_neg ? (~bus.SrcA + XLEN'(1)) : bus.SrcA;
  assign b_mag    = b_neg ? (~bus.SrcB + XLEN'(1)) : bus.SrcB;
  assign div_zero = f3[2] & (bus.SrcB == '0);
  assign div_ovf  = f3[2] & ~f3[0] & (bus.SrcA == {1'b1, {(XLEN-1){1'b0}}}) &
                    (bus.SrcB == '1);

  always_comb begin
    special_res = bus.SrcA;
    if (div_zero)     special_res = f3[1] ? bus.SrcA : '1;
    else if (f3[1])   special_res = '0;
  end

  // One iteration: acc = {hi, lo}; multiplier in lo, quotient shifts into lo
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] div_diff, hi_nxt, lo_nxt, fin;
  logic            div_ge;
  logic [DW-1:0]   mul_nxt, div_nxt, acc_nxt, prod_fix;

  assign mul_sum  = {1'b0, acc[DW-1:XLEN]} + {1'b0, opb};
  assign mul_nxt  = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[DW-1:1]};
  assign div_ge   = {acc[DW-1:XLEN], acc[XLEN-1]} >= {1'b0, opb};
  // Partial remainder stays below the divisor, so XLEN bits of the difference suffice
  assign div_diff = {acc[DW-2:XLEN], acc[XLEN-1]} - opb;
  assign div_nxt  = div_ge ? {div_diff, acc[XLEN-2:0], 1'b1} : {acc[DW-2:0], 1'b0};
  assign acc_nxt  = op[2] ? div_nxt : mul_nxt;
  assign hi_nxt   = acc_nxt[DW-1:XLEN];
  assign lo_nxt   = acc_nxt[XLEN-1:0];
  assign prod_fix = neg_res ? (~acc_nxt + DW'(1)) : acc_nxt;

  // Sign fixup of the final iteration's value
  always_comb begin
    fin = lo_nxt;
    if (!op[2])     fin = (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[DW-1:XLEN];
    else if (op[1]) fin = neg_res ? (~hi_nxt + XLEN'(1)) : hi_nxt;
    else            fin = neg_res ? (~lo_nxt + XLEN'(1)) : lo_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= '0;
      neg_res  <= 1'b0;
      opb      <= '0;
      acc      <= '0;
      result_q <= '0;
    end else if (bus.flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op      <= f3;
            neg_res <= (f3[2] & f3[1]) ? a_neg : (a_neg ^ b_neg);
            if (div_zero | div_ovf) begin
              result_q <= special_res;
              state    <= DONE;
            end else begin
              state <= CALC;
              cnt   <= CW'(XLEN - 1);
              if (f3[2]) begin
                acc <= {{XLEN{1'b0}}, a_mag};
                opb <= b_mag;
              end else begin
                acc <= {{XLEN{1'b0}}, b_mag};
                opb <= a_mag;
              end
            end
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            result_q <= fin;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.Busy      = (state == CALC) | (state == DONE);
  assign bus.out_valid = (state == DONE) & ~bus.flush;
  assign bus.Result    = result_q;
  assign bus.IsMulDiv  = is_md;
endmodule
